branch_step_ctrl: RTL and testbench

BRANCH_STEP_CTRL -- requirements
Module: branch_step_ctrl

---
 rtl/branch_step_ctrl.sv | 159 +++++++++++++++
 tb/tb_branch_step_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/branch_step_ctrl.sv
// Fetch-and-branch T-step sequencer: walks T0..T6 for a conditional branch,
// with a bounded memory wait in T1 and sticky error reporting.
module branch_step_ctrl #(
    parameter logic [4:0]  BR_OPCODE   = 5'b10010,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  IR_31_27,
    input  logic        CON,
    input  logic        mem_rdy,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [15:0] PC_OUT   = 16'h0001;
    localparam logic [15:0] MAR_IN   = 16'h0002;
    localparam logic [15:0] INC_PC   = 16'h0004;
    localparam logic [15:0] Z_IN     = 16'h0008;
    localparam logic [15:0] ZLOW_OUT = 16'h0010;
    localparam logic [15:0] PC_IN    = 16'h0020;
    localparam logic [15:0] READ     = 16'h0040;
    localparam logic [15:0] MDR_IN   = 16'h0080;
    localparam logic [15:0] MDR_OUT  = 16'h0100;
    localparam logic [15:0] IR_IN    = 16'h0200;
    localparam logic [15:0] GRA      = 16'h0400;
    localparam logic [15:0] R_OUT    = 16'h0800;
    localparam logic [15:0] CON_IN   = 16'h1000;
    localparam logic [15:0] Y_IN     = 16'h2000;
    localparam logic [15:0] C_OUT    = 16'h4000;
    localparam logic [15:0] ADD      = 16'h8000;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OPCODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, ERR
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic [1:0]       err_n;
    logic [15:0]      ctrl_q, ctrl_n;
    logic [2:0]       step_n;
    logic             t6_q;

    // Next-state, wait counter and error capture.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        err_n      = err_code;
        case (state)
            IDLE: if (start) state_n = T0;
            T0: begin
                state_n    = T1;
                wait_cnt_n = '0;
            end
            T1: begin
                if (mem_rdy) begin
                    state_n = T2;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    state_n = ERR;
                    err_n   = ERR_TIMEOUT;
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
            end
            T2: state_n = T3;
            T3: begin
                if (IR_31_27 != BR_OPCODE) begin
                    state_n = ERR;
                    err_n   = ERR_OPCODE;
                end else begin
                    state_n = T4;
                end
            end
            T4:   state_n = T5;
            T5:   state_n = T6;
            T6:   state_n = DONE;
            DONE: state_n = IDLE;
            ERR:  state_n = ERR;
            default: begin
                state_n = IDLE;
                err_n   = ERR_NONE;
            end
        endcase
    end

    // Strobes for the state being entered, so the registered outputs track the state.
    always_comb begin
        ctrl_n = '0;
        step_n = 3'd7;
        case (state_n)
            T0: begin
                ctrl_n = PC_OUT | MAR_IN | INC_PC | Z_IN;
                step_n = 3'd0;
            end
            T1: begin
                ctrl_n = READ | MDR_IN;
                if (state != T1) ctrl_n = ctrl_n | ZLOW_OUT | PC_IN;
                step_n = 3'd1;
            end
            T2: begin
                ctrl_n = MDR_OUT | IR_IN;
                step_n = 3'd2;
            end
            T3: begin
                ctrl_n = GRA | R_OUT | CON_IN;
                step_n = 3'd3;
            end
            T4: begin
                ctrl_n = PC_OUT | Y_IN;
                step_n = 3'd4;
            end
            T5: begin
                ctrl_n = C_OUT | ADD | Z_IN;
                step_n = 3'd5;
            end
            T6: begin
                ctrl_n = ZLOW_OUT;
                step_n = 3'd6;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err_code <= ERR_NONE;
            ctrl_q   <= '0;
            step     <= 3'd7;
            busy     <= 1'b0;
            done     <= 1'b0;
            t6_q     <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            err_code <= err_n;
            ctrl_q   <= ctrl_n;
            step     <= step_n;
            busy     <= (step_n != 3'd7);
            done     <= (state_n == DONE);
            t6_q     <= (state_n == T6);
        end
    end

    // The branch PC load follows CON live during T6.
    assign ctrl = ctrl_q | (t6_q && CON ? PC_IN : 16'h0000);

endmodule

// File: tb/tb_branch_step_ctrl.sv
// Self-checking bench for branch_step_ctrl: table-driven transactions, hand
// corner sequences and randomized transactions against a trace-level model.
module tb_branch_step_ctrl;

    localparam logic [4:0] BR  = 5'b10010;
    localparam int         TMO = 15;

    logic        clk = 1'b0;
    logic        reset, start, CON, mem_rdy;
    logic [4:0]  IR_31_27;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        busy, done;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    branch_step_ctrl #(.BR_OPCODE(BR), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .IR_31_27(IR_31_27),
        .CON(CON), .mem_rdy(mem_rdy), .ctrl(ctrl), .step(step),
        .busy(busy), .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic        busy;
        logic        done;
        logic [1:0]  err;
    } obs_t;

    typedef struct {
        int         w;        // T1 cycle index on which mem_rdy rises (> TMO: never)
        logic [4:0] op;
        logic       con;
        int         exp_done; // cycle index of the done pulse after start, -1 if none
        logic [1:0] exp_err;
        int         noise;    // 0 none, 1 random start pulses, 2 start in T2 and DONE
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[$];

    function automatic obs_t mk(logic [15:0] c, int s, logic b, logic d, logic [1:0] e);
        obs_t o;
        o.ctrl = c; o.step = 3'(s); o.busy = b; o.done = d; o.err = e;
        return o;
    endfunction

    function automatic obs_t cur();
        return mk(ctrl, int'(step), busy, done, err_code);
    endfunction

    task automatic check(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ctrl=%h step=%0d busy=%b done=%b err=%b, want ctrl=%h step=%0d busy=%b done=%b err=%b",
                     name, act.ctrl, act.step, act.busy, act.done, act.err,
                     exp.ctrl, exp.step, exp.busy, exp.done, exp.err);
        end
    endtask

    // Expected per-cycle trace, starting with the T0 cycle.
    task automatic build(int w, logic [4:0] op, logic con);
        exp_q.delete();
        exp_q.push_back(mk(16'h000F, 0, 1, 0, 2'b00));
        for (int k = 0; k <= TMO && k <= w; k++)
            exp_q.push_back(mk((k == 0) ? 16'h00F0 : 16'h00C0, 1, 1, 0, 2'b00));
        if (w > TMO) begin
            repeat (3) exp_q.push_back(mk(16'h0000, 7, 0, 0, 2'b10));
            return;
        end
        exp_q.push_back(mk(16'h0300, 2, 1, 0, 2'b00));
        exp_q.push_back(mk(16'h1C00, 3, 1, 0, 2'b00));
        if (op != BR) begin
            repeat (3) exp_q.push_back(mk(16'h0000, 7, 0, 0, 2'b01));
            return;
        end
        exp_q.push_back(mk(16'h2001, 4, 1, 0, 2'b00));
        exp_q.push_back(mk(16'hC008, 5, 1, 0, 2'b00));
        exp_q.push_back(mk(con ? 16'h0030 : 16'h0010, 6, 1, 0, 2'b00));
        exp_q.push_back(mk(16'h0000, 7, 0, 1, 2'b00));
        exp_q.push_back(mk(16'h0000, 7, 0, 0, 2'b00));
    endtask

    // Entered and left at a negedge; reset sampled on the edge in between.
    task automatic apply_reset(string name);
        reset = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        check(name, cur(), mk(16'h0000, 7, 0, 0, 2'b00));
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_txn(string name, vec_t v, int abort_at);
        int   done_idx = -1;
        int   done_cnt = 0;
        obs_t act;
        build(v.w, v.op, v.con);
        IR_31_27 = v.op;
        CON      = v.con;
        start    = 1'b1;
        mem_rdy  = 1'($urandom_range(0, 1));
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            act = cur();
            if (act.done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            check(name, act, exp_q[i]);
            if (i == abort_at) begin
                apply_reset({name, "_rst"});
                return;
            end
            if (i == exp_q.size() - 1) start = 1'b0;
            else if (v.noise == 1)     start = 1'($urandom_range(0, 1));
            else if (v.noise == 2)     start = (i == 2 + v.w) || (i == 7 + v.w);
            else                       start = 1'b0;
            if (i >= 1 && i < 1 + v.w) mem_rdy = 1'b0;
            else if (i == 1 + v.w)     mem_rdy = 1'b1;
            else                       mem_rdy = 1'($urandom_range(0, 1));
        end
        checks++;
        if (done_idx != v.exp_done || done_cnt != ((v.exp_done >= 0) ? 1 : 0) ||
            err_code !== v.exp_err) begin
            errors++;
            $display("FAIL %s_outcome: got done_idx=%0d done_cnt=%0d err=%b, want done_idx=%0d err=%b",
                     name, done_idx, done_cnt, err_code, v.exp_done, v.exp_err);
        end
        if (v.exp_err != 2'b00) begin
            start = 1'b1;
            @(negedge clk);
            check({name, "_err_hold"}, cur(), mk(16'h0000, 7, 0, 0, v.exp_err));
            apply_reset({name, "_err_rst"});
        end
    endtask

    function automatic vec_t mkv(int w, logic [4:0] op, logic con, int noise);
        vec_t v;
        v.w = w; v.op = op; v.con = con; v.noise = noise;
        if (w > TMO)      begin v.exp_done = -1;    v.exp_err = 2'b10; end
        else if (op != BR) begin v.exp_done = -1;   v.exp_err = 2'b01; end
        else              begin v.exp_done = 7 + w; v.exp_err = 2'b00; end
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mem_rdy = 1'b0; CON = 1'b0; IR_31_27 = 5'd0;
        vecs = '{
            '{0,  BR,       1'b1, 7,  2'b00, 0},
            '{0,  BR,       1'b0, 7,  2'b00, 0},
            '{3,  BR,       1'b1, 10, 2'b00, 1},
            '{15, BR,       1'b1, 22, 2'b00, 2},
            '{14, BR,       1'b0, 21, 2'b00, 0},
            '{16, BR,       1'b1, -1, 2'b10, 1},
            '{0,  5'b00011, 1'b1, -1, 2'b01, 0},
            '{2,  5'b11111, 1'b0, -1, 2'b01, 1},
            '{0,  BR,       1'b1, 7,  2'b00, 2}
        };
        @(negedge clk);
        apply_reset("reset_state");

        foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i], -1);

        // Reset mid-sequence in T5, then a clean run right after release.
        run_txn("abort_t5", mkv(0, BR, 1'b1, 0), 5);
        run_txn("after_abort", mkv(0, BR, 1'b1, 0), -1);

        for (int n = 0; n < 40; n++) begin
            int         w;
            logic [4:0] op;
            w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : BR;
            run_txn($sformatf("rand%0d", n), mkv(w, op, 1'($urandom_range(0, 1)), 1), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
